blind_position_ctrl: RTL and testbench

Parametrised motorised-blind controller, the successor to the fixed 3-level blind FSM. Tracks blind position as an N-level counter and drives separate up/down motor outputs with a per-step travel timer. Inserts a motor-off dead time on every stop or reversal. Targets come from manual buttons (open/mid/close) or, in auto mode, from a 2-bit light sensor code.

---
 rtl/blind_position_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_blind_position_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/blind_position_ctrl.sv
// Motorised blind controller: N-level position counter, per-step travel timer,
// dead time on stop/reversal. Optional obstacle reversal under OBSTACLE_DETECT_EN.
module blind_position_ctrl #(
  parameter int NUM_POS     = 8,
  parameter int STEP_CYCLES = 4,
  parameter int DEAD_CYCLES = 3,
  parameter int POS_W       = $clog2(NUM_POS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_open,
  input  logic             btn_mid,
  input  logic             btn_close,
  input  logic             auto_en,
  input  logic [1:0]       sensor,
`ifdef OBSTACLE_DETECT_EN
  input  logic             obstacle,
`endif
  output logic [POS_W-1:0] pos,
  output logic [POS_W-1:0] target,
  output logic             motor_up,
  output logic             motor_down,
  output logic             busy,
  output logic             at_target,
  output logic [1:0]       state_dbg
);

  localparam int TMR_W  = $clog2(STEP_CYCLES) + 1;
  localparam int DEAD_W = $clog2(DEAD_CYCLES) + 1;

  localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(NUM_POS - 1);
  localparam logic [POS_W-1:0]  POS_MID   = POS_W'((NUM_POS - 1) / 2);
  localparam logic [TMR_W-1:0]  STEP_LAST = TMR_W'(STEP_CYCLES - 1);
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'(DEAD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MOVE_UP   = 2'd1,
    MOVE_DOWN = 2'd2,
    DEAD      = 2'd3
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [POS_W-1:0]    pos_nxt;
  logic [POS_W-1:0]    target_nxt;
  logic [POS_W-1:0]    cmd_target;
  logic [POS_W-1:0]    pos_inc;
  logic [POS_W-1:0]    pos_dec;
  logic [TMR_W-1:0]    timer;
  logic [TMR_W-1:0]    timer_nxt;
  logic [DEAD_W-1:0]   dead_cnt;
  logic [DEAD_W-1:0]   dead_nxt;

  assign pos_inc = pos + POS_W'(1);
  assign pos_dec = pos - POS_W'(1);

  // Command arbitration: open > mid > close > auto sensor; nothing means hold.
  always_comb begin
    cmd_target = target;
    if (btn_open) begin
      cmd_target = POS_MAX;
    end else if (btn_mid) begin
      cmd_target = POS_MID;
    end else if (btn_close) begin
      cmd_target = '0;
    end else if (auto_en) begin
      case (sensor)
        2'b10:   cmd_target = POS_MAX;
        2'b01:   cmd_target = POS_MID;
        2'b00:   cmd_target = '0;
        default: cmd_target = target;
      endcase
    end
  end

`ifdef OBSTACLE_DETECT_EN
  // An obstacle while closing forces full open; while it persists, no
  // command may pull the blind further down.
  always_comb begin
    target_nxt = cmd_target;
    if (obstacle) begin
      if (state == MOVE_DOWN) begin
        target_nxt = POS_MAX;
      end else if (cmd_target < pos) begin
        target_nxt = target;
      end
    end
  end
`else
  assign target_nxt = cmd_target;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pos      <= '0;
      target   <= '0;
      timer    <= '0;
      dead_cnt <= '0;
    end else begin
      state    <= state_nxt;
      pos      <= pos_nxt;
      target   <= target_nxt;
      timer    <= timer_nxt;
      dead_cnt <= dead_nxt;
    end
  end

  // Retarget check precedes step completion so a reversal discards the
  // partial step instead of finishing it.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    timer_nxt = timer;
    dead_nxt  = dead_cnt;
    case (state)
      IDLE: begin
        timer_nxt = '0;
        dead_nxt  = '0;
        if (target > pos) begin
          state_nxt = MOVE_UP;
        end else if (target < pos) begin
          state_nxt = MOVE_DOWN;
        end
      end
      MOVE_UP: begin
        if (target <= pos) begin
          state_nxt = DEAD;
          timer_nxt = '0;
          dead_nxt  = '0;
        end else if (timer == STEP_LAST) begin
          timer_nxt = '0;
          pos_nxt   = pos_inc;
          if (pos_inc == target) begin
            state_nxt = DEAD;
            dead_nxt  = '0;
          end
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      MOVE_DOWN: begin
        if (target >= pos) begin
          state_nxt = DEAD;
          timer_nxt = '0;
          dead_nxt  = '0;
        end else if (timer == STEP_LAST) begin
          timer_nxt = '0;
          pos_nxt   = pos_dec;
          if (pos_dec == target) begin
            state_nxt = DEAD;
            dead_nxt  = '0;
          end
        end else begin
          timer_nxt = timer + TMR_W'(1);
        end
      end
      DEAD: begin
        timer_nxt = '0;
        if (dead_cnt == DEAD_LAST) begin
          state_nxt = IDLE;
          dead_nxt  = '0;
        end else begin
          dead_nxt = dead_cnt + DEAD_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        timer_nxt = '0;
        dead_nxt  = '0;
      end
    endcase
  end

  // Outputs decode state directly so an async reset drops the motors at once.
  assign motor_up   = (state == MOVE_UP);
  assign motor_down = (state == MOVE_DOWN);
  assign busy       = (state != IDLE);
  assign at_target  = (state == IDLE) && (pos == target);
  assign state_dbg  = state;

endmodule

// File: tb/tb_blind_position_ctrl.sv
// Directed bench for blind_position_ctrl (NUM_POS=8, STEP_CYCLES=4, DEAD_CYCLES=3).
// Inputs driven and outputs sampled 1 time unit after each rising edge.
module tb_blind_position_ctrl;

  logic       clk;
  logic       reset;
  logic       btn_open;
  logic       btn_mid;
  logic       btn_close;
  logic       auto_en;
  logic [1:0] sensor;
`ifdef OBSTACLE_DETECT_EN
  logic       obstacle;
`endif
  logic [2:0] pos;
  logic [2:0] target;
  logic       motor_up;
  logic       motor_down;
  logic       busy;
  logic       at_target;
  logic [1:0] state_dbg;

  int checks;
  int errors;
  int up_cnt;
  int down_cnt;
  int both_cnt;

  blind_position_ctrl #(
    .NUM_POS(8),
    .STEP_CYCLES(4),
    .DEAD_CYCLES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .btn_open(btn_open),
    .btn_mid(btn_mid),
    .btn_close(btn_close),
    .auto_en(auto_en),
    .sensor(sensor),
`ifdef OBSTACLE_DETECT_EN
    .obstacle(obstacle),
`endif
    .pos(pos),
    .target(target),
    .motor_up(motor_up),
    .motor_down(motor_down),
    .busy(busy),
    .at_target(at_target),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    btn_open  = 1'b0;
    btn_mid   = 1'b0;
    btn_close = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    auto_en = 1'b0;
    sensor = 2'b00;
    clear_inputs();
`ifdef OBSTACLE_DETECT_EN
    obstacle = 1'b0;
`endif
    step(2);
    reset = 1'b0;

    // reset state
    check("rst_pos", pos, 0);
    check("rst_target", target, 0);
    check("rst_motor_up", motor_up, 0);
    check("rst_motor_down", motor_down, 0);
    check("rst_busy", busy, 0);
    check("rst_at_target", at_target, 1);
    check("rst_state", state_dbg, 0);

    // 1: full open from closed
    btn_open = 1'b1;
    step(1);
    btn_open = 1'b0;
    check("s1_target", target, 7);
    check("s1_motor_not_yet", motor_up, 0);
    check("s1_at_target_low", at_target, 0);
    up_cnt = 0;
    down_cnt = 0;
    both_cnt = 0;
    for (int i = 1; i <= 32; i++) begin
      step(1);
      if (motor_up) up_cnt++;
      if (motor_down) down_cnt++;
      if (motor_up && motor_down) both_cnt++;
      if (i == 1) check("s1_motor_up_rise", motor_up, 1);
      if (i == 4) check("s1_pos_before_step", pos, 0);
      if (i == 5) check("s1_pos_first_step", pos, 1);
      if (i == 29) begin
        check("s1_pos_open", pos, 7);
        check("s1_dead_state", state_dbg, 3);
        check("s1_dead_busy", busy, 1);
      end
      if (i == 31) check("s1_dead_still_busy", busy, 1);
    end
    check("s1_drive_cycles", up_cnt, 28);
    check("s1_no_down", down_cnt, 0);
    check("s1_never_both", both_cnt, 0);
    check("s1_idle_busy", busy, 0);
    check("s1_idle_at_target", at_target, 1);

    // 2: simultaneous buttons and saturation at the top
    btn_open = 1'b1;
    btn_close = 1'b1;
    step(1);
    btn_close = 1'b0;
    check("s2_open_beats_close", target, 7);
    step(3);
    btn_open = 1'b0;
    check("s2_sat_busy", busy, 0);
    check("s2_sat_motor_up", motor_up, 0);
    check("s2_sat_pos", pos, 7);
    btn_mid = 1'b1;
    btn_close = 1'b1;
    step(1);
    clear_inputs();
    check("s2_mid_beats_close", target, 3);
    step(1);
    check("s2_motor_down", motor_down, 1);
    step(19);
    check("s2_pos_mid", pos, 3);
    check("s2_busy", busy, 0);
    check("s2_at_target", at_target, 1);

    // 3: reversal two cycles into a step
    btn_open = 1'b1;
    step(1);
    btn_open = 1'b0;
    step(3);
    check("s3_moving_up", motor_up, 1);
    check("s3_pos_mid_step", pos, 3);
    btn_close = 1'b1;
    step(1);
    btn_close = 1'b0;
    check("s3_target_close", target, 0);
    check("s3_still_up", motor_up, 1);
    step(1);
    check("s3_up_dropped", motor_up, 0);
    check("s3_down_off", motor_down, 0);
    check("s3_pos_kept", pos, 3);
    step(3);
    check("s3_dead_down_off", motor_down, 0);
    check("s3_dead_up_off", motor_up, 0);
    step(1);
    check("s3_motor_down", motor_down, 1);
    step(11);
    check("s3_pos_1", pos, 1);
    step(1);
    check("s3_pos_closed", pos, 0);
    check("s3_stop", motor_down, 0);
    step(3);
    check("s3_idle", busy, 0);
    check("s3_at_target", at_target, 1);

    // 4: auto mode
    auto_en = 1'b1;
    sensor = 2'b01;
    step(1);
    check("s4_medium", target, 3);
    sensor = 2'b11;
    step(1);
    check("s4_invalid_holds", target, 3);
    sensor = 2'b10;
    step(1);
    check("s4_bright", target, 7);
    auto_en = 1'b0;
    sensor = 2'b00;
    step(1);
    check("s4_auto_off_holds", target, 7);
    check("s4_moving_up", motor_up, 1);
    step(40);
    check("s4_pos_open", pos, 7);
    check("s4_idle", busy, 0);

    // 5: async reset mid-move
    btn_close = 1'b1;
    step(1);
    btn_close = 1'b0;
    step(6);
    check("s5_moving_down", motor_down, 1);
    #2;
    reset = 1'b1;
    #1;
    check("s5_async_motor_down", motor_down, 0);
    check("s5_async_pos", pos, 0);
    check("s5_async_target", target, 0);
    check("s5_async_busy", busy, 0);
    step(2);
    reset = 1'b0;
    check("s5_released_at_target", at_target, 1);
    btn_mid = 1'b1;
    step(1);
    btn_mid = 1'b0;
    check("s5_resume_target", target, 3);
    step(1);
    check("s5_resume_up", motor_up, 1);
    step(15);
    check("s5_resume_pos", pos, 3);
    check("s5_resume_idle", busy, 0);

`ifdef OBSTACLE_DETECT_EN
    // 6: obstacle while closing
    btn_open = 1'b1;
    step(1);
    btn_open = 1'b0;
    step(30);
    check("s6_pos_open", pos, 7);
    btn_close = 1'b1;
    step(1);
    btn_close = 1'b0;
    step(9);
    check("s6_pos_5", pos, 5);
    check("s6_moving_down", motor_down, 1);
    obstacle = 1'b1;
    step(1);
    check("s6_forced_open", target, 7);
    btn_close = 1'b1;
    step(1);
    check("s6_dead_down_off", motor_down, 0);
    check("s6_dead_pos", pos, 5);
    step(2);
    check("s6_close_ignored", target, 7);
    obstacle = 1'b0;
    btn_close = 1'b0;
    step(2);
    check("s6_reverse_up", motor_up, 1);
    step(8);
    check("s6_pos_reopened", pos, 7);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
